// File: rtl/cricket_pkg.sv
// Shared types and constants for the cricket scoreboard controller
// and the keepscore scoring datapath.
package cricket_pkg;

    localparam int SCORE_W = 7;
    localparam int OVER_W  = 3;
    localparam int WKT_W   = 4;
    localparam int CODE_W  = 3;
    localparam int TGT_W   = SCORE_W + 1;

    localparam logic [CODE_W-1:0] CODE_DOT    = 3'b000;
    localparam logic [CODE_W-1:0] CODE_WIDE   = 3'b101;
    localparam logic [CODE_W-1:0] CODE_SIX    = 3'b110;
    localparam logic [CODE_W-1:0] CODE_WICKET = 3'b111;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_A    = 2'b01;
    localparam logic [1:0] RES_B    = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PLAY,
        ST_ISSUE,
        ST_CHECK,
        ST_BREAK,
        ST_DONE
    } ctrl_state_t;

    // One wider than the score so a maximal first innings cannot wrap.
    function automatic logic [TGT_W-1:0] next_target(
        input logic [SCORE_W-1:0] s
    );
        return {1'b0, s} + TGT_W'(1);
    endfunction

endpackage

// File: rtl/innings_judge.sv
// Combinational end-of-innings and result decision from scorer status.
// Keeps the controller FSM free of scoring rules.
module innings_judge
    import cricket_pkg::*;
#(
    parameter int MAX_OVERS = 5,
    parameter int MAX_WKT   = 10
) (
    input  logic [SCORE_W-1:0] sc_score,
    input  logic [OVER_W-1:0]  sc_over,
    input  logic [WKT_W-1:0]   sc_wicket,
    input  logic [TGT_W-1:0]   target,
    input  logic [SCORE_W-1:0] first_total,
    input  logic [1:0]         innings,
    output logic               end_innings,
    output logic               chase_won,
    output logic [1:0]         res_code
);

    localparam logic [OVER_W-1:0] OVER_LIM = OVER_W'(MAX_OVERS);
    localparam logic [WKT_W-1:0]  WKT_LIM  = WKT_W'(MAX_WKT);

    logic second;

    assign second      = (innings == 2'd2);
    assign chase_won   = second && ({1'b0, sc_score} >= target);
    assign end_innings = (sc_wicket >= WKT_LIM) || (sc_over == OVER_LIM);

    always_comb begin
        res_code = RES_NONE;
        if (chase_won) begin
            res_code = RES_B;
        end else if (sc_score == first_total) begin
            res_code = RES_TIE;
        end else begin
            res_code = RES_A;
        end
    end

endmodule

// File: rtl/innings_controller.sv
// Match sequencer: forwards umpire deliveries to the scorer, detects
// innings end, clears between innings and declares the result.
module innings_controller
    import cricket_pkg::*;
#(
    parameter int MAX_OVERS = 5,
    parameter int MAX_WKT   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [CODE_W-1:0]  in_code,
    output logic               in_ready,
    output logic [CODE_W-1:0]  sc_runs,
    output logic               sc_valid,
    output logic               sc_clear,
    input  logic [SCORE_W-1:0] sc_score,
    input  logic [OVER_W-1:0]  sc_over,
    input  logic [WKT_W-1:0]   sc_wicket,
    output logic [1:0]         innings,
    output logic [SCORE_W-1:0] first_total,
    output logic [TGT_W-1:0]   target,
    output logic               innings_end,
    output logic [1:0]         result,
    output logic               match_done
);

    ctrl_state_t state;
    logic        end_innings;
    logic        chase_won;
    logic [1:0]  judged;

    innings_judge #(
        .MAX_OVERS (MAX_OVERS),
        .MAX_WKT   (MAX_WKT)
    ) u_judge (
        .sc_score    (sc_score),
        .sc_over     (sc_over),
        .sc_wicket   (sc_wicket),
        .target      (target),
        .first_total (first_total),
        .innings     (innings),
        .end_innings (end_innings),
        .chase_won   (chase_won),
        .res_code    (judged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b0;
            sc_runs     <= CODE_DOT;
            sc_valid    <= 1'b0;
            sc_clear    <= 1'b0;
            innings     <= 2'd0;
            first_total <= '0;
            target      <= '0;
            innings_end <= 1'b0;
            result      <= RES_NONE;
            match_done  <= 1'b0;
        end else begin
            sc_valid    <= 1'b0;
            sc_clear    <= 1'b0;
            innings_end <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_CLEAR;
                        innings     <= 2'd1;
                        result      <= RES_NONE;
                        first_total <= '0;
                        target      <= '0;
                        match_done  <= 1'b0;
                        sc_clear    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state    <= ST_PLAY;
                    in_ready <= 1'b1;
                end
                ST_PLAY: begin
                    if (in_valid) begin
                        sc_runs  <= in_code;
                        sc_valid <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (chase_won) begin
                        result      <= RES_B;
                        match_done  <= 1'b1;
                        innings_end <= 1'b1;
                        state       <= ST_DONE;
                    end else if (end_innings) begin
                        innings_end <= 1'b1;
                        if (innings == 2'd1) begin
                            first_total <= sc_score;
                            target      <= next_target(sc_score);
                            state       <= ST_BREAK;
                        end else begin
                            result     <= judged;
                            match_done <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ST_PLAY;
                    end
                end
                ST_BREAK: begin
                    if (start) begin
                        innings  <= 2'd2;
                        sc_clear <= 1'b1;
                        state    <= ST_CLEAR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_innings_controller.sv
// Bench for innings_controller: scorer model, match-level reference,
// table-driven innings, directed corner cases and random matches.
module tb_innings_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = 3'b000;
    logic       in_ready;
    logic [2:0] sc_runs;
    logic       sc_valid;
    logic       sc_clear;
    logic [6:0] sc_score = '0;
    logic [2:0] sc_over = '0;
    logic [3:0] sc_wicket = '0;
    logic [1:0] innings;
    logic [6:0] first_total;
    logic [7:0] target;
    logic       innings_end;
    logic [1:0] result;
    logic       match_done;

    int n_checks = 0;
    int n_fail = 0;

    innings_controller #(.MAX_OVERS(5), .MAX_WKT(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .in_ready    (in_ready),
        .sc_runs     (sc_runs),
        .sc_valid    (sc_valid),
        .sc_clear    (sc_clear),
        .sc_score    (sc_score),
        .sc_over     (sc_over),
        .sc_wicket   (sc_wicket),
        .innings     (innings),
        .first_total (first_total),
        .target      (target),
        .innings_end (innings_end),
        .result      (result),
        .match_done  (match_done)
    );

    always #5 clk = ~clk;

    // Behavioural keepscore: updates the cycle after sc_valid.
    int bio = 0;
    always @(posedge clk) begin
        if (sc_clear) begin
            sc_score  <= '0;
            sc_over   <= '0;
            sc_wicket <= '0;
            bio       <= 0;
        end else if (sc_valid) begin
            case (sc_runs)
                3'b101: sc_score <= sc_score + 7'd1;
                3'b110: sc_score <= sc_score + 7'd6;
                3'b111: sc_wicket <= sc_wicket + 4'd1;
                default: sc_score <= sc_score + 7'(sc_runs);
            endcase
            if (sc_runs != 3'b101) begin
                if (bio == 5) begin
                    bio     <= 0;
                    sc_over <= sc_over + 3'd1;
                end else begin
                    bio <= bio + 1;
                end
            end
        end
    end

    // Match-level reference: plain totals, legal ball count, decisions.
    int m_inn = 0, m_score = 0, m_balls = 0, m_wkt = 0;
    int m_first = 0, m_target = 0, m_result = 0, m_done = 0;

    typedef struct {
        logic [2:0] code;
        int         exp_score;
        int         exp_wkt;
        int         exp_end;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input logic [2:0] code, output int ended);
        int c;
        c = int'(code);
        if (c == 5) m_score += 1;
        else if (c == 6) begin m_score += 6; m_balls++; end
        else if (c == 7) begin m_wkt++; m_balls++; end
        else begin m_score += c; m_balls++; end
        ended = 0;
        if (m_inn == 2 && m_score >= m_target) begin
            m_result = 2;
            m_done = 1;
            ended = 1;
        end else if (m_wkt >= 10 || m_balls / 6 == 5) begin
            ended = 1;
            if (m_inn == 1) begin
                m_first = m_score;
                m_target = m_score + 1;
            end else begin
                m_result = (m_score == m_first) ? 3 : 1;
                m_done = 1;
            end
        end
    endtask

    task automatic model_check(input int ended);
        chk("innings_end", int'(innings_end), ended);
        chk("in_ready", int'(in_ready), ended ? 0 : 1);
        chk("result", int'(result), m_result);
        chk("first_total", int'(first_total), m_first);
        chk("target", int'(target), m_target);
        chk("match_done", int'(match_done), m_done);
        chk("innings", int'(innings), m_inn);
        chk("scorer_score", int'(sc_score), m_score);
        chk("scorer_over", int'(sc_over), m_balls / 6);
        chk("scorer_wkt", int'(sc_wicket), m_wkt);
    endtask

    task automatic begin_innings(input int inn);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear_pulse", int'(sc_clear), 1);
        chk("clear_innings", int'(innings), inn);
        chk("clear_ready", int'(in_ready), 0);
        tick();
        chk("clear_once", int'(sc_clear), 0);
        chk("play_ready", int'(in_ready), 1);
        m_inn = inn;
        m_score = 0;
        m_balls = 0;
        m_wkt = 0;
        if (inn == 1) begin
            m_first = 0;
            m_target = 0;
            m_result = 0;
            m_done = 0;
        end
    endtask

    // Returns at the cycle after CHECK.
    task automatic deliver(input logic [2:0] code, output int ended);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_code = code;
        tick();
        chk("issue_valid", int'(sc_valid), 1);
        chk("issue_runs", int'(sc_runs), int'(code));
        in_valid = 1'b0;
        tick();
        chk("check_valid", int'(sc_valid), 0);
        chk("check_ready", int'(in_ready), 0);
        tick();
        model_apply(code, ended);
        model_check(ended);
    endtask

    task automatic idle_probe(input string name);
        int nv;
        nv = 0;
        in_valid = 1'b1;
        in_code = 3'b100;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sc_valid) nv++;
            chk({name, "_ready"}, int'(in_ready), 0);
        end
        in_valid = 1'b0;
        chk({name, "_no_issue"}, nv, 0);
    endtask

    task automatic run_to_end(input int runs);
        int e, k;
        e = 0;
        k = 0;
        while (runs > 0 && e == 0) begin
            deliver((runs >= 4) ? 3'b100 : 3'(runs), e);
            runs -= (runs >= 4) ? 4 : runs;
        end
        while (e == 0 && k < 40) begin
            deliver(3'b000, e);
            k++;
        end
        chk("innings_ended", e, 1);
    endtask

    initial begin
        int e, nv;
        logic [2:0] c;

        tbl[0] = '{3'b100, 8, 0, 0};
        tbl[1] = '{3'b100, 12, 0, 0};
        tbl[2] = '{3'b011, 15, 0, 0};
        for (int i = 0; i < 10; i++)
            tbl[3 + i] = '{3'b111, 15, i + 1, (i == 9) ? 1 : 0};

        tick();
        tick();
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_valid", int'(sc_valid), 0);
        chk("rst_clear", int'(sc_clear), 0);
        chk("rst_runs", int'(sc_runs), 0);
        chk("rst_innings", int'(innings), 0);
        chk("rst_first", int'(first_total), 0);
        chk("rst_target", int'(target), 0);
        chk("rst_end", int'(innings_end), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_done", int'(match_done), 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", int'(in_ready), 0);

        begin_innings(1);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_play_clear", int'(sc_clear), 0);
        chk("start_in_play_ready", int'(in_ready), 1);

        in_valid = 1'b1;
        in_code = 3'b100;
        tick();
        chk("hs_n1_valid", int'(sc_valid), 1);
        chk("hs_n1_runs", int'(sc_runs), 4);
        chk("hs_n1_ready", int'(in_ready), 0);
        tick();
        chk("hs_n2_valid", int'(sc_valid), 0);
        chk("hs_n2_ready", int'(in_ready), 0);
        tick();
        chk("hs_n3_valid", int'(sc_valid), 0);
        chk("hs_n3_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        model_apply(3'b100, e);
        model_check(e);

        foreach (tbl[i]) begin
            deliver(tbl[i].code, e);
            chk("tbl_score", int'(sc_score), tbl[i].exp_score);
            chk("tbl_wkt", int'(sc_wicket), tbl[i].exp_wkt);
            chk("tbl_end", int'(innings_end), tbl[i].exp_end);
        end
        chk("allout_first", int'(first_total), 15);
        chk("allout_target", int'(target), 16);
        tick();
        chk("end_pulse_once", int'(innings_end), 0);
        idle_probe("break");

        begin_innings(2);
        deliver(3'b100, e);
        deliver(3'b100, e);
        deliver(3'b010, e);
        chk("chase_pre", int'(match_done), 0);
        deliver(3'b110, e);
        chk("chase_result", int'(result), 2);
        chk("chase_done", int'(match_done), 1);
        chk("chase_end", int'(innings_end), 1);
        idle_probe("done");

        begin_innings(1);
        run_to_end(15);
        chk("ov_first", int'(first_total), 15);
        begin_innings(2);
        run_to_end(15);
        chk("ov_tie", int'(result), 3);

        begin_innings(1);
        run_to_end(15);
        begin_innings(2);
        run_to_end(14);
        chk("ov_a_wins", int'(result), 1);

        for (int m = 0; m < 15; m++) begin
            for (int inn = 1; inn <= 2; inn++) begin
                begin_innings(inn);
                e = 0;
                for (int k = 0; k < 80 && e == 0; k++) begin
                    c = 3'($urandom_range(0, 7));
                    if (m_score > 100 && c != 3'b111) c = 3'b000;
                    if (k > 60) c = 3'b111;
                    deliver(c, e);
                end
                chk("rand_ended", e, 1);
                if (m_done != 0) break;
            end
            chk("rand_done", int'(match_done), 1);
        end

        begin_innings(1);
        deliver(3'b100, e);
        for (int i = 0; i < 10; i++) deliver(3'b111, e);
        chk("pre_rst_target", int'(target), 5);
        begin_innings(2);
        in_valid = 1'b1;
        in_code = 3'b001;
        tick();
        chk("pre_rst_issue", int'(sc_valid), 1);
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("mid_rst_ready", int'(in_ready), 0);
        chk("mid_rst_valid", int'(sc_valid), 0);
        chk("mid_rst_runs", int'(sc_runs), 0);
        chk("mid_rst_innings", int'(innings), 0);
        chk("mid_rst_first", int'(first_total), 0);
        chk("mid_rst_target", int'(target), 0);
        chk("mid_rst_result", int'(result), 0);
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (sc_valid || in_ready) nv++;
        end
        chk("post_rst_idle", nv, 0);
        begin_innings(1);
        chk("restart_first", int'(first_total), 0);
        chk("restart_target", int'(target), 0);
        deliver(3'b101, e);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/innings_controller.md
Name: innings_controller

Overview:
Match-level sequencer for the cricket scoreboard. It takes delivery events from the umpire panel over a valid/ready handshake and forwards each one as a single-cycle update to the keepscore scoring datapath. It reads back the scorer status, detects end of innings, clears the scorer between innings, computes the chase target and declares the match result.

Parameters:
MAX_OVERS, 5, overs per innings (1..7; over counter is 3 bits)
MAX_WKT, 10, wickets that end an innings (1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins innings 1 from IDLE or from DONE, begins innings 2 from BREAK; ignored in every other state
in_valid  input  1  delivery event present
in_code  input  3  delivery code; see cricket_pkg
in_ready  output  1  controller accepts a delivery this cycle
sc_runs  output  3  delivery code forwarded to the scorer
sc_valid  output  1  scorer updates on cycles where this is 1
sc_clear  output  1  one-cycle scorer clear
sc_score  input  7  scorer total
sc_over  input  3  completed overs
sc_wicket  input  4  wickets fallen
innings  output  2  0 = none, 1 = first innings, 2 = second innings
first_total  output  7  latched first-innings score
target  output  8  first_total + 1
innings_end  output  1  one-cycle pulse at end of either innings
result  output  2  00 none, 01 team A (batting first) wins, 10 team B wins, 11 tie
match_done  output  1  high in DONE

Behaviour:
- Delivery codes:
  - 000 dot ball
  - 001..100 runs 1..4
  - 101 wide: 1 run, ball not counted
  - 110 six
  - 111 wicket
- Clock and reset: single clock; reset is synchronous, active-high.
- Reset values: all outputs 0. State is IDLE.
- States: IDLE, CLEAR, PLAY, ISSUE, CHECK, BREAK, DONE.
- IDLE:
  - in_ready = 0.
  - On start: go to CLEAR. Set innings = 1. Clear result and first_total. Set target = 0.
- CLEAR:
  - sc_clear = 1 for exactly one cycle, then go to PLAY.
- PLAY:
  - in_ready = 1.
  - When in_valid is high: register in_code into sc_runs and go to ISSUE.
- ISSUE:
  - sc_valid = 1 for exactly one cycle; in_ready = 0.
  - The scorer status reflects the delivery in the next cycle.
- CHECK:
  - in_ready = 0.
  - Evaluate the following conditions, in priority order, from sc_* inputs:
    1. Innings 2 only: if sc_score >= target, set result = 10 and go to DONE.
    2. If sc_wicket >= MAX_WKT or sc_over == MAX_OVERS, the innings ends:
       - Innings 1: latch first_total = sc_score and target = sc_score + 1 (8-bit, no overflow). Go to BREAK.
       - Innings 2: set result = 11 if sc_score == first_total, else 01. Go to DONE.
    3. Otherwise return to PLAY.
  - innings_end pulses for 1 cycle in the cycle after CHECK that ends an innings, including a chase win.
- Throughput and latency:
  - Acceptance at cycle N gives sc_valid at N+1, CHECK at N+2, and in_ready again at N+3.
  - Maximum rate is one delivery per 3 cycles.
- BREAK:
  - in_ready = 0.
  - On start: set innings = 2 and go to CLEAR.
- DONE:
  - match_done = 1; result, first_total and target are held.
  - in_valid is ignored.
  - On start: behave as IDLE start.
- Ignored and dropped inputs:
  - in_valid outside PLAY is ignored and produces no side effect.
  - start outside IDLE, BREAK and DONE is ignored.
- Reset mid-match: on the next edge, all outputs take their reset values and state is IDLE. Any delivery in flight (ISSUE or CHECK) is dropped. The scorer's own reset is independent.
- Wides:
  - The controller does not count balls; the over limit relies on sc_over only.
  - A wide that reaches the target in innings 2 wins the match.

Decomposition:
- cricket_pkg holds:
  - delivery code constants (CODE_DOT, CODE_WIDE, CODE_SIX, CODE_WICKET)
  - result encodings (RES_NONE, RES_A, RES_B, RES_TIE)
  - the controller state enum
  - score, over and wicket widths shared with keepscore
- One natural sub-module: innings_judge.
  - Purely combinational.
  - Takes sc_*, target, first_total and innings.
  - Outputs end_innings, chase_won and the result code.
  - Keeps the FSM to sequencing only.

Test Plan:
- Start/clear: reset 2 cycles, then start pulse -> sc_clear high exactly 1 cycle; innings = 1; in_ready = 1 on the following cycle.
- Handshake timing: accept code 100 at cycle N -> sc_runs = 100 and sc_valid = 1 only at N+1; in_ready = 0 at N+1 and N+2, 1 at N+3; in_valid held high in PLAY causes no duplicate issue.
- All out: innings 1 with 15 runs then 10 wickets (bench scorer model) -> first_total = 15, target = 16, innings_end 1 pulse, state BREAK, in_ready = 0 until start.
- Chase win: innings 2 at score 10, deliver 110 -> result = 10, match_done = 1, innings_end pulse; a later in_valid produces no sc_valid.
- Overs exhausted: innings 2 reaches sc_over = 5 at score 15 -> result = 11; repeat at score 14 -> result = 01.
- Reset mid-innings 2 during ISSUE -> next cycle all outputs 0 and state IDLE; a following start begins innings 1 with first_total = 0.
